convolutor_z_reader: RTL and testbench

CONVOLUTOR_Z_READER -- requirements
Module: convolutor_z_reader

---
 rtl/convolutor_z_reader.sv | 131 +++++++++++++
 tb/tb_convolutor_z_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/convolutor_z_reader.sv
// Drains the convolution result memory (Z) into a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle memory read latency.
`timescale 1ns/1ps

// state    | meaning
// S_IDLE   | waiting for start_i
// S_READ   | addresses remaining to be read from Z memory
// S_DRAIN  | all reads issued, stream still holds or awaits data
// S_FINISH | one cycle, done_o asserted, then back to S_IDLE
module convolutor_z_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int X_SIZE     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   sizeY_i,
    output logic [ADDR_WIDTH:0]     memZ_addr_o,
    output logic                    memZ_rd_o,
    input  logic [2*DATA_WIDTH-1:0] dataZ_i,
    output logic [2*DATA_WIDTH-1:0] m_data_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int AW1 = ADDR_WIDTH + 1;
    localparam int ZW  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_q;
    logic [AW1-1:0]   len_q;
    logic [AW1-1:0]   rd_cnt_q;
    logic [AW1-1:0]   beat_cnt_q;
    logic [AW1-1:0]   last_addr_q;
    logic             inflight_q;
    logic [ZW-1:0]    fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    logic             pop;
    logic             issue;
    logic [2:0]       credit;
    logic [AW1-1:0]   len_new;

    assign m_valid_o   = (count_q != 2'd0);
    assign m_data_o    = fifo_q[rd_ptr_q];
    assign m_last_o    = m_valid_o && (beat_cnt_q == len_q - AW1'(1));
    assign busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_FINISH);
    assign memZ_rd_o   = issue;
    assign memZ_addr_o = issue ? rd_cnt_q : last_addr_q;

    // A read may only go out if the FIFO is guaranteed room for its data
    // one cycle later, counting the word already in flight.
    always_comb begin
        pop     = m_valid_o && m_ready_i;
        credit  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue   = (state_q == S_READ) && (rd_cnt_q < len_q) && (credit <= 3'd1);
        len_new = '0;
        if (sizeY_i != '0) begin
            len_new = AW1'(X_SIZE) + AW1'(sizeY_i) - AW1'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            inflight_q <= issue;
            count_q    <= count_q + {1'b0, inflight_q} - {1'b0, pop};
            if (issue) begin
                last_addr_q <= rd_cnt_q;
                rd_cnt_q    <= rd_cnt_q + AW1'(1);
            end
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= dataZ_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                beat_cnt_q <= beat_cnt_q + AW1'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q      <= len_new;
                        rd_cnt_q   <= '0;
                        beat_cnt_q <= '0;
                        state_q    <= (len_new == '0) ? S_FINISH : S_READ;
                    end
                end
                S_READ: begin
                    if (issue && (rd_cnt_q == len_q - AW1'(1))) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && m_last_o) begin
                        state_q <= S_FINISH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convolutor_z_reader.sv
// Self-checking bench for convolutor_z_reader: directed table, random drains,
// and a hand-written mid-drain reset sequence.
`timescale 1ns/1ps

module tb_convolutor_z_reader;

    localparam int X_SIZE = 5;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [4:0]  sizeY_i;
    logic [5:0]  memZ_addr_o;
    logic        memZ_rd_o;
    logic [15:0] dataZ_i;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;
    logic        busy_o;
    logic        done_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned mem_off  = 0;
    string       cur_tag  = "reset";

    convolutor_z_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .X_SIZE(X_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .sizeY_i    (sizeY_i),
        .memZ_addr_o(memZ_addr_o),
        .memZ_rd_o  (memZ_rd_o),
        .dataZ_i    (dataZ_i),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_last_o   (m_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memval(input int a);
        return 16'(a + 100 + int'(mem_off));
    endfunction

    // Z memory: data returned exactly one cycle after the read strobe.
    always @(posedge clk) begin
        if (memZ_rd_o) dataZ_i <= memval(int'(memZ_addr_o));
        else           dataZ_i <= 16'($urandom);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0d expected %0d", cur_tag, name, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic do_run(input int sy, input int mode, input int restart_at, input int exp_len);
        int L, k, n_rd, n_beat, n_done, done_cyc, first_busy, last_busy, n_busy, last_hs, budget;
        int rd_addr[64], rd_cyc[64], bt_data[64], bt_last[64], bt_cyc[64];
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        bit          fin;
        L = (sy == 0) ? 0 : X_SIZE + sy - 1;
        n_rd = 0; n_beat = 0; n_done = 0; n_busy = 0;
        done_cyc = -1; first_busy = -1; last_busy = -1; last_hs = -1;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        budget = 4 * L + 20;
        fin = 0;
        @(posedge clk); #1;
        k = 0;
        start_i = 1'b1; sizeY_i = 5'(sy); m_ready_i = rdy(mode, 0);
        while (!fin) begin
            @(negedge clk);
            if (memZ_rd_o) begin
                if (n_rd < 64) begin rd_addr[n_rd] = int'(memZ_addr_o); rd_cyc[n_rd] = k; end
                n_rd++;
            end
            if (prev_stall) begin
                chk("stall_valid", int'(m_valid_o), 1);
                chk("stall_data", int'(m_data_o), int'(prev_data));
                chk("stall_last", int'(m_last_o), int'(prev_last));
            end
            if (m_last_o) chk("last_needs_valid", int'(m_valid_o), 1);
            if (m_valid_o && m_ready_i) begin
                if (n_beat < 64) begin
                    bt_data[n_beat] = int'(m_data_o); bt_last[n_beat] = int'(m_last_o); bt_cyc[n_beat] = k;
                end
                n_beat++;
                last_hs = k;
            end
            if (done_o) begin n_done++; if (done_cyc < 0) done_cyc = k; end
            if (busy_o) begin n_busy++; if (first_busy < 0) first_busy = k; last_busy = k; end
            chk("outstanding_le_2", int'((n_rd - n_beat) <= 2), 1);
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
            if (done_cyc >= 0 && k >= done_cyc + 2) begin
                fin = 1;
            end else if (k >= budget) begin
                n_checks++; n_errors++;
                $display("FAIL %s/timeout: no completion after %0d cycles", cur_tag, k);
                fin = 1;
            end else begin
                @(posedge clk); #1;
                k++;
                start_i   = (k == restart_at);
                sizeY_i   = (k == restart_at) ? 5'd9 : 5'(sy);
                m_ready_i = rdy(mode, k);
            end
        end
        start_i = 1'b0;
        m_ready_i = 1'b1;

        chk("beats", n_beat, L);
        chk("beats_table", n_beat, exp_len);
        chk("reads", n_rd, L);
        chk("done_pulses", n_done, 1);
        for (int i = 0; i < n_beat && i < L && i < 64; i++) begin
            chk($sformatf("beat%0d_data", i), bt_data[i], int'(memval(i)));
            chk($sformatf("beat%0d_last", i), bt_last[i], int'(i == L - 1));
        end
        for (int i = 0; i < n_rd && i < 64; i++) begin
            chk($sformatf("read%0d_addr", i), rd_addr[i], i);
        end
        if (L == 0) begin
            chk("done_cycle", done_cyc, 1);
            chk("busy_cycles", n_busy, 0);
        end else begin
            chk("done_cycle", done_cyc, last_hs + 1);
            chk("busy_first", first_busy, 1);
            chk("busy_last", last_busy, last_hs);
            chk("busy_cycles", n_busy, last_hs);
        end
        if (mode == 0) begin
            for (int i = 0; i < n_rd && i < 64; i++)   chk($sformatf("read%0d_cycle", i), rd_cyc[i], 1 + i);
            for (int i = 0; i < n_beat && i < 64; i++) chk($sformatf("beat%0d_cycle", i), bt_cyc[i], 3 + i);
            if (L > 0) chk("done_cycle_abs", done_cyc, L + 3);
        end
    endtask

    task automatic chk_outputs_zero(input string what);
        chk({what, "_addr"},  int'(memZ_addr_o), 0);
        chk({what, "_rd"},    int'(memZ_rd_o), 0);
        chk({what, "_valid"}, int'(m_valid_o), 0);
        chk({what, "_last"},  int'(m_last_o), 0);
        chk({what, "_data"},  int'(m_data_o), 0);
        chk({what, "_busy"},  int'(busy_o), 0);
        chk({what, "_done"},  int'(done_o), 0);
    endtask

    typedef struct {
        string name;
        int    sy;
        int    mode;
        int    restart_at;
        int    exp_len;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{"full_rate_y3",  3,  0, -1, 7};
        tbl[1] = '{"stall_100_y3",  3,  1, -1, 7};
        tbl[2] = '{"empty_y0",      0,  0, -1, 0};
        tbl[3] = '{"max_y31",       31, 0, -1, 35};
        tbl[4] = '{"restart_y3",    3,  0, 4,  7};
        tbl[5] = '{"rand_rdy_y3",   3,  2, -1, 7};
        tbl[6] = '{"stall_100_y1",  1,  1, -1, 5};

        rst = 1'b1; start_i = 1'b0; sizeY_i = '0; m_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("after_reset");
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            cur_tag = tbl[i].name;
            mem_off = 0;
            do_run(tbl[i].sy, tbl[i].mode, tbl[i].restart_at, tbl[i].exp_len);
        end

        for (int r = 0; r < 8; r++) begin
            int sy;
            sy = int'($urandom_range(0, 31));
            cur_tag = $sformatf("random%0d_y%0d", r, sy);
            mem_off = $urandom_range(0, 60000);
            do_run(sy, 2, -1, (sy == 0) ? 0 : X_SIZE + sy - 1);
        end

        // Reset during the third beat, then a start held together with reset.
        cur_tag = "midreset";
        mem_off = 0;
        @(posedge clk); #1;
        start_i = 1'b1; sizeY_i = 5'd3; m_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("beat3_valid", int'(m_valid_o), 1);
        chk("beat3_data", int'(m_data_o), 102);
        @(posedge clk); #1;
        start_i = 1'b1; sizeY_i = 5'd2;
        @(negedge clk);
        chk_outputs_zero("post_reset");
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("idle_busy", int'(busy_o), 0);
            chk("idle_rd", int'(memZ_rd_o), 0);
            chk("idle_valid", int'(m_valid_o), 0);
            chk("no_done", int'(done_o), 0);
            @(posedge clk); #1;
        end
        cur_tag = "after_reset_y2";
        do_run(2, 0, -1, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
